shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 163 ++++++++++++++++
 tb/tb_shift_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SHL/SHR/SAR/ROL/ROR with a valid/ready handshake.
// Each stage applies its slice of the shift count; range and illegal-op fixups happen last.
module shift_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [CW-1:0]    in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_err
);

  localparam int unsigned LW  = $clog2(WIDTH);
  localparam int unsigned GRP = LW / STAGES;

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Count bits owned by stage k, left in place; the last stage takes the remainder.
  function automatic logic [LW-1:0] stage_amt(input int unsigned k, input logic [LW-1:0] c);
    int unsigned lo;
    int unsigned n;
    logic [LW-1:0] mask;
    lo   = k * GRP;
    n    = (k == STAGES - 1) ? LW - lo : GRP;
    mask = LW'((32'd1 << n) - 32'd1);
    return ((c >> lo) & mask) << lo;
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                input logic sgn, input logic [LW-1:0] s);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
    case (op)
      OP_SHL:  return d << s;
      OP_SHR:  return d >> s;
      OP_SAR:  return (d >> s) | fill;
      OP_ROL:  return (d << s) | (d >> (WIDTH - 32'(s)));
      OP_ROR:  return (d >> s) | (d << (WIDTH - 32'(s)));
      default: return d;
    endcase
  endfunction

  // Index k holds the inputs of stage k: the ports for k = 0, slot k-1 otherwise.
  logic             w_v   [STAGES];
  logic [WIDTH-1:0] w_d   [STAGES];
  logic [2:0]       w_op  [STAGES];
  logic             w_sgn [STAGES];
  logic             w_rng [STAGES];
  logic [LW-1:0]    w_cnt [STAGES];
  logic [STAGES-1:0] w_slot_v;
  logic [STAGES-1:0] w_en;

  assign in_ready = !rst && w_en[0];
  assign w_v[0]   = in_valid && in_ready;
  assign w_d[0]   = in_a;
  assign w_op[0]  = in_op;
  assign w_sgn[0] = in_a[WIDTH-1];
  assign w_rng[0] = in_cnt >= CW'(WIDTH);
  assign w_cnt[0] = in_cnt[LW-1:0];

  // A slot may load unless it and every slot after it are full while the output is stalled.
  always_comb begin : p_enable
    logic full;
    full = 1'b1;
    w_en = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full    = full & w_slot_v[k];
      w_en[k] = out_ready | ~full;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [LW-1:0]    w_amt;
    logic [WIDTH-1:0] w_sh;

    assign w_amt = stage_amt(k, w_cnt[k]);
    assign w_sh  = apply_op(w_op[k], w_d[k], w_sgn[k], w_amt);

    if (k < STAGES - 1) begin : g_mid
      logic             r_v;
      logic [WIDTH-1:0] r_d;
      logic [2:0]       r_op;
      logic             r_sgn;
      logic             r_rng;
      logic [LW-1:0]    r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (w_en[k]) begin
          r_v   <= w_v[k];
          r_d   <= w_sh;
          r_op  <= w_op[k];
          r_sgn <= w_sgn[k];
          r_rng <= w_rng[k];
          r_cnt <= w_cnt[k];
        end
      end

      assign w_slot_v[k] = r_v;
      assign w_v[k+1]    = r_v;
      assign w_d[k+1]    = r_d;
      assign w_op[k+1]   = r_op;
      assign w_sgn[k+1]  = r_sgn;
      assign w_rng[k+1]  = r_rng;
      assign w_cnt[k+1]  = r_cnt;
    end else begin : g_last
      logic             w_ill;
      logic [WIDTH-1:0] w_fin;
      logic             r_v;
      logic [WIDTH-1:0] r_res;
      logic             r_zero;
      logic             r_err;

      assign w_ill = w_op[k] > OP_ROR;

      // Out-of-range counts saturate; rotates ignore the range flag.
      always_comb begin
        w_fin = w_sh;
        if (w_ill) begin
          w_fin = '0;
        end else if (w_rng[k]) begin
          if (w_op[k] == OP_SHL || w_op[k] == OP_SHR) w_fin = '0;
          else if (w_op[k] == OP_SAR)                 w_fin = {WIDTH{w_sgn[k]}};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v    <= 1'b0;
          r_res  <= '0;
          r_zero <= 1'b0;
          r_err  <= 1'b0;
        end else if (w_en[k]) begin
          r_v    <= w_v[k];
          r_res  <= w_fin;
          r_zero <= (w_fin == '0);
          r_err  <= w_ill;
        end
      end

      assign w_slot_v[k] = r_v;
      assign out_valid   = r_v;
      assign out_res     = r_res;
      assign out_zero    = r_zero;
      assign out_err     = r_err;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations for the documented examples.
module tb_shift_pipe;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [CW-1:0] in_cnt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_res;
  logic          out_zero;
  logic          out_err;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(W), .STAGES(S), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_cnt   (in_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_zero (out_zero),
    .out_err  (out_err)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  exp_t q[$];

  logic         held = 1'b0;
  logic [W-1:0] h_res;
  logic         h_zero;
  logic         h_err;

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [CW-1:0] cnt);
    exp_t e;
    int c;
    int r;
    logic signed [W-1:0] sa;
    c = int'(cnt);
    r = c % W;
    e.err = 1'b0;
    case (op)
      3'd0: e.res = (c >= W) ? '0 : a << c;
      3'd1: e.res = (c >= W) ? '0 : a >> c;
      3'd2: begin
        if (c >= W) e.res = {W{a[W-1]}};
        else begin
          sa = $signed(a);
          sa = sa >>> c;
          e.res = sa;
        end
      end
      3'd3: e.res = (r == 0) ? a : ((a << r) | (a >> (W - r)));
      3'd4: e.res = (r == 0) ? a : ((a >> r) | (a << (W - r)));
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transfer monitor: scoreboard bookkeeping at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_cnt));
      held   = out_valid && !out_ready;
      h_res  = out_res;
      h_zero = out_zero;
      h_err  = out_err;
    end
  end

  // Compare process on the opposite edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rdy_in_rst", 64'(in_ready), 64'(0));
    end else begin
      if (held) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_res", 64'(out_res), 64'(h_res));
        check("stall_flags", 64'({out_zero, out_err}), 64'({h_zero, h_err}));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", out_res);
        end else begin
          check("sb_res", 64'(out_res), 64'(q[0].res));
          check("sb_zero", 64'(out_zero), 64'(q[0].zero));
          check("sb_err", 64'(out_err), 64'(q[0].err));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick;
    check({nm, "_empty"}, 64'(q.size()), 64'(0));
  endtask

  task automatic single(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [CW-1:0] cnt, input logic [W-1:0] er, input logic ez,
                        input logic ee);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_cnt    = cnt;
    check({nm, "_rdy"}, 64'(in_ready), 64'(1));
    tick;
    in_valid = 1'b0;
    in_op    = ~op;
    in_a     = ~a;
    in_cnt   = ~cnt;
    check({nm, "_early"}, 64'(out_valid), 64'(0));
    tick;
    check({nm, "_valid"}, 64'(out_valid), 64'(1));
    check({nm, "_res"}, 64'(out_res), 64'(er));
    check({nm, "_zero"}, 64'(out_zero), 64'(ez));
    check({nm, "_err"}, 64'(out_err), 64'(ee));
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] cl[7];
    logic [W-1:0]  al[4];
    logic          ir_log[14];
    int            sent;
    int            base;
    int            idx;
    int            cyc;

    cl = '{8'd0, 8'd1, 8'd7, 8'd31, 8'd32, 8'd33, 8'd255};
    al = '{32'h8000_0001, 32'hDEAD_BEEF, 32'h7000_0000, 32'hF000_000F};

    // Reset state.
    rst = 1'b1;
    repeat (3) tick;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_res", 64'(out_res), 64'(0));
    check("rst_flags", 64'({out_zero, out_err}), 64'(0));
    check("rst_rdy", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 64'(in_ready), 64'(1));

    // Documented examples with hand-computed results.
    single("shl31", 3'd0, 32'h0000_0001, 8'd31, 32'h8000_0000, 1'b0, 1'b0);
    single("shr32", 3'd1, 32'h0000_0001, 8'd32, 32'h0000_0000, 1'b1, 1'b0);
    single("sar4", 3'd2, 32'h8000_0000, 8'd4, 32'hF800_0000, 1'b0, 1'b0);
    single("sar200", 3'd2, 32'h8000_0000, 8'd200, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("sar40", 3'd2, 32'h7000_0000, 8'd40, 32'h0000_0000, 1'b1, 1'b0);
    single("rol1", 3'd3, 32'h8000_0001, 8'd1, 32'h0000_0003, 1'b0, 1'b0);
    single("ror33", 3'd4, 32'h8000_0001, 8'd33, 32'hC000_0000, 1'b0, 1'b0);
    single("rol64", 3'd3, 32'h8000_0001, 8'd64, 32'h8000_0001, 1'b0, 1'b0);
    single("shr4", 3'd1, 32'h0000_00F0, 8'd4, 32'h0000_000F, 1'b0, 1'b0);
    single("illegal", 3'd6, 32'hFFFF_FFFF, 8'd5, 32'h0000_0000, 1'b1, 1'b1);
    single("after_ill", 3'd0, 32'h0000_0005, 8'd0, 32'h0000_0005, 1'b0, 1'b0);

    // Back-to-back 8 ops with the consumer stalled in cycles 3..6.
    sent = 0;
    base = n_out;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      in_op     = 3'(sent % 5);
      in_a      = 32'h1234_5678 + 32'(sent) * 32'h1111_0101;
      in_cnt    = 8'(sent * 3 + 1);
      #1;
      ir_log[c] = in_ready;
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0;
    drain("b2b");
    check("b2b_sent", 64'(sent), 64'(8));
    check("b2b_delivered", 64'(n_out - base), 64'(8));
    check("b2b_full_accept", 64'(ir_log[2]), 64'(1));
    check("b2b_stall_rdy", 64'(ir_log[3]), 64'(0));

    // Every op against boundary counts, consumer ready two cycles out of three.
    idx = 0;
    cyc = 0;
    base = n_out;
    while (idx < 56 && cyc < 400) begin
      out_ready = (cyc % 3 != 0);
      in_valid  = 1'b1;
      in_op     = 3'(idx / 7);
      in_cnt    = cl[idx % 7];
      in_a      = al[idx % 4];
      #1;
      if (in_ready) idx++;
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    drain("vec");
    check("vec_sent", 64'(idx), 64'(56));
    check("vec_delivered", 64'(n_out - base), 64'(56));

    // Reset with two operations in flight.
    base = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_a      = 32'h0000_0001;
    in_cnt    = 8'd1;
    tick;
    in_a = 32'h0000_0010;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_rdy", 64'(in_ready), 64'(0));
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_res", 64'(out_res), 64'(0));
    check("midrst_after_rdy", 64'(in_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      tick;
      check("midrst_quiet", 64'(out_valid), 64'(0));
    end
    check("midrst_none_out", 64'(n_out - base), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
